// File: rtl/wavegen_pkg.sv
// ---------------------------------------------------------------------------
// wavegen_pkg
//  Shared constants, types and helpers for the waveform sample loader.
//  LOAD_OPCODE  : header opcode that opens a write frame
//  WORD_W       : SPI word width (MSB first)
//  DATA_W       : sample width written into the sample RAM
//  BANK_W/OFS_W : bank select / offset-within-bank widths
//  loader_state_t : loader FSM states
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package wavegen_pkg;

   localparam int WORD_W      = 16;
   localparam int DATA_W      = 10;
   localparam int BANK_W      = 2;
   localparam int OFS_W       = 9;
   localparam int ADDR_W      = BANK_W + OFS_W;
   localparam int SYNC_STAGES = 2;

   localparam logic [3:0] LOAD_OPCODE = 4'hA;

   // Saturation ceiling of the per-frame write counter (one full bank).
   localparam logic [OFS_W:0] WORDS_MAX = {1'b1, {OFS_W{1'b0}}};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HEADER = 2'd1,
      DATA   = 2'd2,
      ERROR  = 2'd3
   } loader_state_t;

   // Increment that sticks at WORDS_MAX.
   function automatic logic [OFS_W:0] sat_inc(input logic [OFS_W:0] v);
      logic [OFS_W:0] r;
      if (v == WORDS_MAX) begin
         r = v;
      end else begin
         r = v + 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/wave_loader_sync_edge.sv
// ---------------------------------------------------------------------------
// spi_sync_edge
//  Brings one asynchronous SPI pin into the clk domain through STAGES flops
//  and produces single-cycle rise/fall pulses from the synchronized level.
//  Ports:
//   clk, rst_n : system clock, async active-low reset
//   din_i      : asynchronous input pin
//   level_o    : synchronized level
//   rise_o     : one-clk pulse on a synchronized 0->1 transition
//   fall_o     : one-clk pulse on a synchronized 1->0 transition
//  All flops reset to 0. For cs_n this matters: if cs_n is already low when
//  reset releases, no fall is seen, so a frame interrupted by reset stays
//  ignored until cs_n goes high and low again.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module spi_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], din_i};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign level_o = sync_q[STAGES-1];
   assign rise_o  = sync_q[STAGES-1] & ~prev_q;
   assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/wave_loader.sv
// ---------------------------------------------------------------------------
// wave_loader
//  SPI-slave (mode 0) writer for the 2048 x 10 waveform sample RAM.
//  A frame is one header word (opcode 4'hA, bank, start offset) followed by
//  data words; each data word produces one write strobe to the RAM.
//  Ports:
//   clk, rst_n    : system clock, async active-low reset
//   sclk, cs_n,
//   mosi          : asynchronous SPI slave inputs
//   miso          : echo of the previous completed word (0 unless echo built)
//   wr_en         : one-clk RAM write strobe
//   wr_addr       : {bank, offset} write address
//   wr_data       : sample written
//   busy          : frame in progress (HEADER or DATA)
//   frame_err     : sticky bad-header flag, cleared on the next cs_n fall
//   words_written : samples written in the current/last frame, saturating
//  Build option: define WAVE_LOADER_ECHO_EN to shift the previous completed
//  word back out on miso; otherwise miso is tied low.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module wave_loader
   import wavegen_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              frame_err,
   output logic [OFS_W:0]    words_written
);

   // ---------------- input synchronizers ----------------
   logic sclk_lvl, sclk_rise, sclk_fall;
   logic cs_lvl, cs_rise, cs_fall;
   logic mosi_lvl, mosi_rise, mosi_fall;

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk(clk), .rst_n(rst_n), .din_i(sclk),
      .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
      .clk(clk), .rst_n(rst_n), .din_i(cs_n),
      .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
      .clk(clk), .rst_n(rst_n), .din_i(mosi),
      .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
   );

   // Only the levels/edges listed below drive logic; the rest are by-products
   // of reusing one synchronizer cell for all three pins.
`ifdef WAVE_LOADER_ECHO_EN
   logic unused_sync;
   assign unused_sync = ^{sclk_lvl, cs_lvl, mosi_rise, mosi_fall};
`else
   logic unused_sync;
   assign unused_sync = ^{sclk_lvl, sclk_fall, cs_lvl, mosi_rise, mosi_fall};
`endif

   // ---------------- state ----------------
   loader_state_t     state_q, state_d;
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   logic [WORD_W-2:0] shift_q, shift_d;      // MSB of a word is never needed after completion
   logic [BANK_W-1:0] bank_q, bank_d;
   logic [OFS_W-1:0]  ofs_q, ofs_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              busy_q, busy_d;
   logic              frame_err_q, frame_err_d;
   logic [OFS_W:0]    words_q, words_d;

   logic              in_frame;
   logic              word_done;
   logic [WORD_W-1:0] word_w;

   assign in_frame  = (state_q != IDLE);
   assign word_done = in_frame && sclk_rise && (bit_cnt_q == 4'd15);
   // Completed word including the bit sampled on this very edge.
   assign word_w    = {shift_q, mosi_lvl};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         bit_cnt_q   <= 4'd0;
         shift_q     <= '0;
         bank_q      <= '0;
         ofs_q       <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
         words_q     <= '0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         bank_q      <= bank_d;
         ofs_q       <= ofs_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         busy_q      <= busy_d;
         frame_err_q <= frame_err_d;
         words_q     <= words_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      bank_d      = bank_q;
      ofs_d       = ofs_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      busy_d      = busy_q;
      frame_err_d = frame_err_q;
      words_d     = words_q;

      // Bit collection runs in every active state; the counter wraps 15 -> 0
      // exactly when a word completes.
      if (in_frame && sclk_rise) begin
         shift_d   = word_w[WORD_W-2:0];
         bit_cnt_d = bit_cnt_q + 4'd1;
      end

      if (word_done) begin
         case (state_q)
            HEADER: begin
               if (word_w[15:12] == LOAD_OPCODE) begin
                  state_d = DATA;
                  bank_d  = word_w[11:10];
                  ofs_d   = word_w[OFS_W-1:0];
               end else begin
                  state_d     = ERROR;
                  frame_err_d = 1'b1;
                  busy_d      = 1'b0;
               end
            end
            DATA: begin
               wr_en_d   = 1'b1;
               wr_addr_d = {bank_q, ofs_q};
               wr_data_d = word_w[DATA_W-1:0];
               ofs_d     = ofs_q + 1'b1;   // natural wrap keeps the write inside the bank
               words_d   = sat_inc(words_q);
            end
            default: ;
         endcase
      end

      // cs_n deassertion overrides the state change above but leaves a write
      // issued on the same clk intact.
      if (cs_rise) begin
         state_d   = IDLE;
         bit_cnt_d = 4'd0;
         busy_d    = 1'b0;
      end else if (cs_fall && !in_frame) begin
         state_d     = HEADER;
         bit_cnt_d   = 4'd0;
         shift_d     = '0;
         frame_err_d = 1'b0;
         words_d     = '0;
         busy_d      = 1'b1;
      end
   end

   assign wr_en         = wr_en_q;
   assign wr_addr       = wr_addr_q;
   assign wr_data       = wr_data_q;
   assign busy          = busy_q;
   assign frame_err     = frame_err_q;
   assign words_written = words_q;

   // ---------------- optional miso echo ----------------
`ifdef WAVE_LOADER_ECHO_EN
   logic [WORD_W-1:0] echo_q, echo_d;
   logic              miso_q, miso_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         echo_q <= '0;
         miso_q <= 1'b0;
      end else begin
         echo_q <= echo_d;
         miso_q <= miso_d;
      end
   end

   // bit_cnt_q counts bits already received in the current word, so on the
   // fall that follows the k-th rise the master expects echo bit 15-k next.
   always_comb begin
      echo_d = echo_q;
      miso_d = miso_q;
      if (cs_fall) begin
         echo_d = '0;
         miso_d = 1'b0;
      end else begin
         if (word_done) begin
            echo_d = word_w;
         end
         if (in_frame && sclk_fall) begin
            miso_d = echo_q[4'd15 - bit_cnt_q];
         end
      end
   end

   assign miso = miso_q;
`else
   assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_wave_loader.sv
`timescale 1ns/1ps
module tb_wave_loader;

   localparam int HALF = 80;   // SPI half period: 8 system clocks

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sclk;
   logic        cs_n;
   logic        mosi;
   logic        miso;
   logic        wr_en;
   logic [10:0] wr_addr;
   logic [9:0]  wr_data;
   logic        busy;
   logic        frame_err;
   logic [9:0]  words_written;

   int          n_cmp = 0;
   int          n_err = 0;

   logic [10:0] cap_addr[$];
   logic [9:0]  cap_data[$];
   logic        wr_en_prev = 1'b0;
   logic [15:0] miso_rx;

   always #5 clk = ~clk;

   wave_loader dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
      .miso(miso), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .frame_err(frame_err), .words_written(words_written)
   );

   // Write monitor, sampled on the falling clock edge.
   always @(negedge clk) begin
      if (wr_en) begin
         cap_addr.push_back(wr_addr);
         cap_data.push_back(wr_data);
         $display("write addr=%h data=%h", wr_addr, wr_data);
         n_cmp++;
         if (wr_en_prev !== 1'b0) begin
            n_err++;
            $display("FAIL wr_en_width: wr_en high on consecutive clocks, got %b want 0 on previous clk", wr_en_prev);
         end
      end
      wr_en_prev <= wr_en;
   end

   // ---------------- SPI master helpers ----------------
   task automatic spi_bits(input logic [15:0] w, input int n);
      for (int i = 15; i > 15 - n; i--) begin
         mosi = w[i];
         #HALF;
         miso_rx = {miso_rx[14:0], miso};
         sclk = 1'b1;
         #HALF;
         sclk = 1'b0;
      end
   endtask

   task automatic spi_word(input logic [15:0] w);
      spi_bits(w, 16);
   endtask

   task automatic cs_begin();
      cs_n = 1'b0;
      #HALF;
   endtask

   task automatic cs_end();
      #HALF;
      cs_n = 1'b1;
      #(2 * HALF);
   endtask

   task automatic clear_caps();
      cap_addr.delete();
      cap_data.delete();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
      #32;
      @(negedge clk);
      n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
      n_cmp++; if (wr_addr !== 11'h000) begin n_err++; $display("FAIL reset_wr_addr: got %h want 000", wr_addr); end
      n_cmp++; if (wr_data !== 10'h000) begin n_err++; $display("FAIL reset_wr_data: got %h want 000", wr_data); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
      n_cmp++; if (words_written !== 10'd0) begin n_err++; $display("FAIL reset_words: got %0d want 0", words_written); end
      n_cmp++; if (miso !== 1'b0) begin n_err++; $display("FAIL reset_miso: got %b want 0", miso); end
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   // Header A800: bank 2, offset 0 -> base address 11'h400.
   task automatic test_basic_write();
      clear_caps();
      cs_begin();
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_hdr: got %b want 1", busy); end
      spi_word(16'hA800);
      spi_word(16'hFC01);   // upper six bits ignored -> sample 001
      spi_word(16'h03FF);
      spi_word(16'h0155);
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_data: got %b want 1", busy); end
      cs_end();
      n_cmp++; if (cap_addr.size() !== 3) begin n_err++; $display("FAIL basic_count: got %0d writes want 3", cap_addr.size()); end
      if (cap_addr.size() == 3) begin
         n_cmp++; if (cap_addr[0] !== 11'h400 || cap_data[0] !== 10'h001) begin n_err++; $display("FAIL basic_w0: got %h/%h want 400/001", cap_addr[0], cap_data[0]); end
         n_cmp++; if (cap_addr[1] !== 11'h401 || cap_data[1] !== 10'h3FF) begin n_err++; $display("FAIL basic_w1: got %h/%h want 401/3ff", cap_addr[1], cap_data[1]); end
         n_cmp++; if (cap_addr[2] !== 11'h402 || cap_data[2] !== 10'h155) begin n_err++; $display("FAIL basic_w2: got %h/%h want 402/155", cap_addr[2], cap_data[2]); end
      end
      n_cmp++; if (words_written !== 10'd3) begin n_err++; $display("FAIL basic_words: got %0d want 3", words_written); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_end: got %b want 0", busy); end
      n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL basic_frame_err: got %b want 0", frame_err); end
   endtask

   // Header A1FF: bank 0, offset 511 -> second write wraps to 000 in bank 0.
   task automatic test_wrap();
      clear_caps();
      cs_begin();
      spi_word(16'hA1FF);
      spi_word(16'h02AA);
      spi_word(16'h00F0);
      cs_end();
      n_cmp++; if (cap_addr.size() !== 2) begin n_err++; $display("FAIL wrap_count: got %0d writes want 2", cap_addr.size()); end
      if (cap_addr.size() == 2) begin
         n_cmp++; if (cap_addr[0] !== 11'h1FF || cap_data[0] !== 10'h2AA) begin n_err++; $display("FAIL wrap_w0: got %h/%h want 1ff/2aa", cap_addr[0], cap_data[0]); end
         n_cmp++; if (cap_addr[1] !== 11'h000 || cap_data[1] !== 10'h0F0) begin n_err++; $display("FAIL wrap_w1: got %h/%h want 000/0f0", cap_addr[1], cap_data[1]); end
      end
      n_cmp++; if (words_written !== 10'd2) begin n_err++; $display("FAIL wrap_words: got %0d want 2", words_written); end
   endtask

   // Bad opcode 5 -> ERROR, no writes; next frame (AC10: bank 3, offset 0x10) clears the flag.
   task automatic test_bad_header();
      clear_caps();
      cs_begin();
      spi_word(16'h5000);
      spi_word(16'h0011);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bad_busy: got %b want 0", busy); end
      spi_word(16'h0022);
      spi_word(16'h0033);
      cs_end();
      n_cmp++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL bad_frame_err: got %b want 1", frame_err); end
      n_cmp++; if (cap_addr.size() !== 0) begin n_err++; $display("FAIL bad_no_write: got %0d writes want 0", cap_addr.size()); end
      n_cmp++; if (words_written !== 10'd0) begin n_err++; $display("FAIL bad_words: got %0d want 0", words_written); end
      cs_begin();
      n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL bad_clear: got %b want 0", frame_err); end
      spi_word(16'hAC10);
      spi_word(16'h0077);
      cs_end();
      n_cmp++; if (cap_addr.size() !== 1) begin n_err++; $display("FAIL bad_next_count: got %0d writes want 1", cap_addr.size()); end
      if (cap_addr.size() == 1) begin
         n_cmp++; if (cap_addr[0] !== 11'h610 || cap_data[0] !== 10'h077) begin n_err++; $display("FAIL bad_next_w0: got %h/%h want 610/077", cap_addr[0], cap_data[0]); end
      end
   endtask

   // Header A600: bank 1, reserved bit set, offset 0 -> address 200.
   task automatic test_abort();
      clear_caps();
      cs_begin();
      spi_word(16'hA600);
      spi_word(16'h0011);
      spi_bits(16'hFFFF, 7);
      cs_end();
      n_cmp++; if (cap_addr.size() !== 1) begin n_err++; $display("FAIL abort_count: got %0d writes want 1", cap_addr.size()); end
      if (cap_addr.size() == 1) begin
         n_cmp++; if (cap_addr[0] !== 11'h200 || cap_data[0] !== 10'h011) begin n_err++; $display("FAIL abort_w0: got %h/%h want 200/011", cap_addr[0], cap_data[0]); end
      end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
      n_cmp++; if (words_written !== 10'd1) begin n_err++; $display("FAIL abort_words: got %0d want 1", words_written); end
      clear_caps();
      cs_begin();
      spi_word(16'hA600);
      spi_word(16'h0022);
      cs_end();
      n_cmp++; if (cap_addr.size() !== 1) begin n_err++; $display("FAIL abort_next_count: got %0d writes want 1", cap_addr.size()); end
      if (cap_addr.size() == 1) begin
         n_cmp++; if (cap_addr[0] !== 11'h200 || cap_data[0] !== 10'h022) begin n_err++; $display("FAIL abort_next_w0: got %h/%h want 200/022", cap_addr[0], cap_data[0]); end
      end
   endtask

   // Header A205: bank 0, reserved bit set, offset 5 -> address 005.
   task automatic test_reset_mid_frame();
      clear_caps();
      cs_begin();
      spi_word(16'hA205);
      spi_word(16'h00AB);
      spi_bits(16'hFFFF, 5);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (wr_data !== 10'h000) begin n_err++; $display("FAIL rstmid_wr_data: got %h want 000", wr_data); end
      n_cmp++; if (wr_addr !== 11'h000) begin n_err++; $display("FAIL rstmid_wr_addr: got %h want 000", wr_addr); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      n_cmp++; if (words_written !== 10'd0) begin n_err++; $display("FAIL rstmid_words: got %0d want 0", words_written); end
      n_cmp++; if (wr_en !== 1'b0 || frame_err !== 1'b0 || miso !== 1'b0) begin n_err++; $display("FAIL rstmid_misc: got wr_en=%b frame_err=%b miso=%b want 0/0/0", wr_en, frame_err, miso); end
      rst_n = 1'b1;
      clear_caps();
      spi_bits(16'hFFFF, 11);
      spi_word(16'h0155);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy_after: got %b want 0", busy); end
      cs_end();
      n_cmp++; if (cap_addr.size() !== 0) begin n_err++; $display("FAIL rstmid_no_write: got %0d writes want 0", cap_addr.size()); end
      n_cmp++; if (words_written !== 10'd0) begin n_err++; $display("FAIL rstmid_words_after: got %0d want 0", words_written); end
      cs_begin();
      spi_word(16'hA205);
      spi_word(16'h00CD);
      cs_end();
      n_cmp++; if (cap_addr.size() !== 1) begin n_err++; $display("FAIL rstmid_next_count: got %0d writes want 1", cap_addr.size()); end
      if (cap_addr.size() == 1) begin
         n_cmp++; if (cap_addr[0] !== 11'h005 || cap_data[0] !== 10'h0CD) begin n_err++; $display("FAIL rstmid_next_w0: got %h/%h want 005/0cd", cap_addr[0], cap_data[0]); end
      end
   endtask

   task automatic test_echo();
      cs_begin();
      spi_word(16'hA400);
      spi_word(16'h0123);
      cs_end();
`ifdef WAVE_LOADER_ECHO_EN
      n_cmp++; if (miso_rx !== 16'hA400) begin n_err++; $display("FAIL echo_word: got %h want a400", miso_rx); end
`else
      n_cmp++; if (miso_rx !== 16'h0000) begin n_err++; $display("FAIL echo_tied_low: got %h want 0000", miso_rx); end
`endif
   endtask

   initial begin
      miso_rx = '0;
      test_reset();
      test_basic_write();
      test_wrap();
      test_bad_header();
      test_abort();
      test_reset_mid_frame();
      test_echo();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
